// File: rtl/mod_addsub.sv
// -----------------------------------------------------------------------------
// mod_addsub
//
// Limb-serial modular adder/subtractor over a prime field. Computes
// (a + b) mod MODULUS when op=0 and (a - b) mod MODULUS when op=1. The design
// works on LIMB_WIDTH bits per cycle, so it needs no full-width adder. Two
// chains run side by side:
//   add : s = a + b (carry c),  t = s - p (borrow w)
//   sub : d = a - b (borrow w), t = d + p (carry c)
// The FIN state picks t or the primary chain result from the final carry and
// borrow bits.
//
// Optional feature (compile-time macro MOD_ADDSUB_RANGE_CHECK_EN):
//   When defined, a and b are compared against MODULUS at capture. If either
//   one is out of range, the operation still takes the normal number of
//   cycles, but it finishes with err=1 and result=0. When the macro is not
//   defined, err is tied to 0 and no comparator is built.
//
// Parameters:
//   DATA_WIDTH : operand/result width; must be a multiple of LIMB_WIDTH and
//                hold at least two limbs
//   LIMB_WIDTH : bits processed per cycle
//   MODULUS    : field prime p, with p > 2^(DATA_WIDTH-1)
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : operation request, taken only while ready=1
//   op     : 0 = add, 1 = subtract (captured with start)
//   a, b   : operands (captured with start), expected < MODULUS
//   ready  : high while idle
//   result : reduced result; holds until the next completed operation
//   done   : one-cycle completion pulse
//   err    : range-check flag; same lifetime as done
// -----------------------------------------------------------------------------
module mod_addsub #(
   parameter int                    DATA_WIDTH = 448,
   parameter int                    LIMB_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] MODULUS    = {{223{1'b1}}, 1'b0, {224{1'b1}}}
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  done,
   output logic                  err
);

   // state | meaning
   // IDLE  | ready=1, waiting for start
   // RUN   | one limb per cycle on both chains, counter counts down
   // FIN   | select and register result, pulse done

   localparam int NUM_LIMBS = DATA_WIDTH / LIMB_WIDTH;
   localparam int CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LIMBS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic                  capture;
   logic                  run_en;
   logic                  fin_en;
   logic                  cnt_tc;

   logic [CNT_W-1:0]      cnt;
   logic                  op_q;
   logic                  carry;
   logic                  borrow;
   logic                  carry_nx;
   logic                  borrow_nx;

   logic [DATA_WIDTH-1:0] a_sh;
   logic [DATA_WIDTH-1:0] b_sh;
   logic [DATA_WIDTH-1:0] p_sh;
   logic [DATA_WIDTH-1:0] prim_sh;
   logic [DATA_WIDTH-1:0] corr_sh;

   logic [LIMB_WIDTH-1:0] limb_a;
   logic [LIMB_WIDTH-1:0] limb_b;
   logic [LIMB_WIDTH-1:0] limb_p;
   logic [LIMB_WIDTH-1:0] prim_limb;
   logic [LIMB_WIDTH-1:0] corr_limb;
   logic [LIMB_WIDTH:0]   chain1;
   logic [LIMB_WIDTH:0]   chain2;

   logic                  use_corr;
   logic [DATA_WIDTH-1:0] sel_result;
   logic                  range_bad;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   assign cnt_tc = (cnt == '0);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start)  state_nx = S_RUN;
         S_RUN:   if (cnt_tc) state_nx = S_FIN;
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs and datapath strobes
   // ---------------------------------------------------------------------------
   always_comb begin
      ready   = 1'b0;
      run_en  = 1'b0;
      fin_en  = 1'b0;
      case (state)
         S_IDLE:  ready  = 1'b1;
         S_RUN:   run_en = 1'b1;
         S_FIN:   fin_en = 1'b1;
         default: ready  = 1'b0;
      endcase
   end

   assign capture = ready & start;

   // ---------------------------------------------------------------------------
   // Limb arithmetic. Each chain works on LIMB_WIDTH+1 bits. For a
   // subtraction, the top bit is set exactly when the limb result went
   // negative, so that bit is the borrow out.
   // ---------------------------------------------------------------------------
   assign limb_a = a_sh[LIMB_WIDTH-1:0];
   assign limb_b = b_sh[LIMB_WIDTH-1:0];
   assign limb_p = p_sh[LIMB_WIDTH-1:0];

   always_comb begin
      chain1    = '0;
      chain2    = '0;
      prim_limb = '0;
      carry_nx  = carry;
      borrow_nx = borrow;
      if (!op_q) begin
         chain1    = {1'b0, limb_a} + {1'b0, limb_b} + {{LIMB_WIDTH{1'b0}}, carry};
         prim_limb = chain1[LIMB_WIDTH-1:0];
         chain2    = {1'b0, prim_limb} - {1'b0, limb_p} - {{LIMB_WIDTH{1'b0}}, borrow};
         carry_nx  = chain1[LIMB_WIDTH];
         borrow_nx = chain2[LIMB_WIDTH];
      end else begin
         chain1    = {1'b0, limb_a} - {1'b0, limb_b} - {{LIMB_WIDTH{1'b0}}, borrow};
         prim_limb = chain1[LIMB_WIDTH-1:0];
         chain2    = {1'b0, prim_limb} + {1'b0, limb_p} + {{LIMB_WIDTH{1'b0}}, carry};
         borrow_nx = chain1[LIMB_WIDTH];
         carry_nx  = chain2[LIMB_WIDTH];
      end
      corr_limb = chain2[LIMB_WIDTH-1:0];
   end

   // add: a carry out means a+b >= 2^N > p. No borrow means s >= p. Either
   //      way, the reduced result is t.
   // sub: a borrow means a < b, so p must be added back.
   always_comb begin
      if (!op_q) begin
         use_corr = carry | ~borrow;
      end else begin
         use_corr = borrow;
      end
      sel_result = use_corr ? corr_sh : prim_sh;
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         p_sh    <= '0;
         prim_sh <= '0;
         corr_sh <= '0;
         cnt     <= '0;
         op_q    <= 1'b0;
         carry   <= 1'b0;
         borrow  <= 1'b0;
         result  <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (capture) begin
            a_sh   <= a;
            b_sh   <= b;
            p_sh   <= MODULUS;
            op_q   <= op;
            cnt    <= LAST_CNT;
            carry  <= 1'b0;
            borrow <= 1'b0;
         end else if (run_en) begin
            // Operands shift right one limb at a time. Each chain result
            // enters at the top, so after NUM_LIMBS shifts the limbs are in
            // their proper positions.
            a_sh    <= a_sh >> LIMB_WIDTH;
            b_sh    <= b_sh >> LIMB_WIDTH;
            p_sh    <= p_sh >> LIMB_WIDTH;
            prim_sh <= {prim_limb, prim_sh[DATA_WIDTH-1:LIMB_WIDTH]};
            corr_sh <= {corr_limb, corr_sh[DATA_WIDTH-1:LIMB_WIDTH]};
            cnt     <= cnt - CNT_W'(1);
            carry   <= carry_nx;
            borrow  <= borrow_nx;
         end else if (fin_en) begin
            result <= range_bad ? '0 : sel_result;
            done   <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Optional operand range check
   // ---------------------------------------------------------------------------
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
   logic oor_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         oor_q <= 1'b0;
         err   <= 1'b0;
      end else begin
         err <= 1'b0;
         if (capture) begin
            oor_q <= (a >= MODULUS) || (b >= MODULUS);
         end else if (fin_en) begin
            err <= oor_q;
         end
      end
   end

   assign range_bad = oor_q;
`else
   assign range_bad = 1'b0;
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub.sv
module tb_mod_addsub;

   localparam int W = 448;
   localparam logic [W-1:0] P = {{223{1'b1}}, 1'b0, {224{1'b1}}};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic [W-1:0] result;
   logic         done;
   logic         err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mod_addsub dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .result (result),
      .done   (done),
      .err    (err)
   );

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Run one operation. Latency is counted in edges after the capture edge.
   task automatic do_op(input logic o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        output logic [W-1:0] r, output logic e, output int lat,
                        output bit rdy_ok, output bit got_done);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = xa;
      b     = xb;
      @(posedge clk);
      #1;
      start    = 1'b0;
      a        = {14{$urandom()}};
      b        = {14{$urandom()}};
      op       = ~o;
      lat      = 0;
      got_done = 1'b0;
      r        = '0;
      e        = 1'b0;
      rdy_ok   = !ready && !done;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat      = i;
            got_done = 1'b1;
            r        = result;
            e        = err;
            rdy_ok   = rdy_ok && ready;
            break;
         end
         rdy_ok = rdy_ok && !ready;
      end
   endtask

   logic [W-1:0] r;
   logic         e;
   int           lat;
   bit           rdy_ok;
   bit           got;
   int           n_done;
   int           first_at;
   int           second_at;
   logic [W-1:0] two447;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;

      two447 = '0;
      two447[447] = 1'b1;
      vecs[0]  = '{1'b1, W'(5),   W'(3),   W'(2)};
      vecs[1]  = '{1'b1, W'(1),   W'(2),   P - W'(1)};
      vecs[2]  = '{1'b0, P - W'(1), W'(2), W'(1)};
      vecs[3]  = '{1'b0, P - W'(1), P - W'(1), P - W'(2)};
      vecs[4]  = '{1'b0, W'(7),   W'(8),   W'(15)};
      vecs[5]  = '{1'b0, P - W'(1), W'(1), W'(0)};
      vecs[6]  = '{1'b1, P - W'(1), P - W'(1), W'(0)};
      vecs[7]  = '{1'b1, W'(0),   P - W'(1), W'(1)};
      vecs[8]  = '{1'b0, two447,  two447,  (W'(1) << 224) + W'(1)};
      vecs[9]  = '{1'b0, W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), W'(1) << 64};
      vecs[10] = '{1'b0, W'(0),   W'(0),   W'(0)};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready",  W'(ready),  W'(1));
      chk("reset_done",   W'(done),   W'(0));
      chk("reset_result", result,     W'(0));
      chk("reset_err",    W'(err),    W'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      for (int k = 0; k < 11; k++) begin
         do_op(vecs[k].op, vecs[k].a, vecs[k].b, r, e, lat, rdy_ok, got);
         chk($sformatf("vec%0d_done_seen", k), W'(got), W'(1));
         chk($sformatf("vec%0d_result", k), r, vecs[k].exp);
         chk($sformatf("vec%0d_latency", k), W'(lat), W'(8));
         chk($sformatf("vec%0d_ready_seq", k), W'(rdy_ok), W'(1));
         chk($sformatf("vec%0d_err", k), W'(e), W'(0));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_done_pulse", k), W'(done), W'(0));
      end

      // Start held high for 20 edges with operands changed after capture.
      // The first capture is at edge 1 and the second at edge 10, and both
      // operand sets sum to 15.
      @(negedge clk);
      start  = 1'b1;
      op     = 1'b0;
      a      = W'(7);
      b      = W'(8);
      n_done = 0;
      first_at  = 0;
      second_at = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 3) begin
            a = W'(10);
            b = W'(5);
         end
         if (done) begin
            n_done++;
            if (n_done == 1) first_at = i;
            else if (n_done == 2) second_at = i;
            chk($sformatf("held_result%0d", n_done), result, W'(15));
         end
      end
      start = 1'b0;
      chk("held_done_count", W'(n_done),    W'(2));
      chk("held_first_at",   W'(first_at),  W'(9));
      chk("held_second_at",  W'(second_at), W'(18));
      // Drain the third operation, which was captured at edge 19.
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            got = 1'b1;
            chk("held_third_result", result, W'(15));
         end
      end
      chk("held_third_done_seen", W'(got), W'(1));

      // Reset during the fourth RUN cycle
      @(negedge clk);
      start = 1'b1;
      op    = 1'b0;
      a     = W'(7);
      b     = W'(8);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_ready",  W'(ready), W'(1));
      chk("midrst_result", result,    W'(0));
      chk("midrst_done",   W'(done),  W'(0));
      chk("midrst_err",    W'(err),   W'(0));
      @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      chk("midrst_no_done", W'(n_done), W'(0));
      do_op(1'b1, W'(0), W'(1), r, e, lat, rdy_ok, got);
      chk("post_rst_done_seen", W'(got), W'(1));
      chk("post_rst_result",    r,       P - W'(1));
      chk("post_rst_latency",   W'(lat), W'(8));

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
      do_op(1'b0, P, W'(0), r, e, lat, rdy_ok, got);
      chk("range_bad_done", W'(got), W'(1));
      chk("range_bad_err",  W'(e),   W'(1));
      chk("range_bad_res",  r,       W'(0));
      chk("range_bad_lat",  W'(lat), W'(8));
      @(posedge clk);
      #1;
      chk("range_err_pulse", W'(err), W'(0));
      do_op(1'b0, P - W'(1), W'(0), r, e, lat, rdy_ok, got);
      chk("range_ok_done", W'(got), W'(1));
      chk("range_ok_err",  W'(e),   W'(0));
      chk("range_ok_res",  r,       P - W'(1));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
